// File: rtl/gpu_blit.sv
// CHIP-8/SCHIP sprite blitter: XORs a sprite from shared memory into a 1-bpp
// framebuffer in the same memory, tracks pixel collisions, and clears the screen.
module gpu_blit #(
  parameter int unsigned SCREEN_W     = 64,
  parameter int unsigned SCREEN_H     = 32,
  parameter int unsigned SCREEN_START = 'h100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        draw,
  input  logic        clear,
  input  logic        wide,
  input  logic        wrap,
  input  logic [15:0] addr,
  input  logic [3:0]  lines,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic        ready,
  output logic        collision,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_write_byte,
  input  logic [7:0]  mem_read_byte
);

  localparam int unsigned ROW_BYTES    = SCREEN_W / 8;
  localparam int unsigned SCREEN_BYTES = SCREEN_W * SCREEN_H / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_NEXT_ROW, S_FETCH, S_LOAD, S_STORE, S_CLEAR
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_ready, w_ready_nxt;
  logic        r_collision, w_collision_nxt;
  logic        r_mem_read, w_mem_read_nxt;
  logic        r_mem_write, w_mem_write_nxt;
  logic [15:0] r_mem_addr, w_mem_addr_nxt;
  logic [7:0]  r_mem_wbyte, w_mem_wbyte_nxt;
  logic        r_wide, w_wide_nxt;
  logic        r_wrap, w_wrap_nxt;
  logic [7:0]  r_x0, w_x0_nxt;
  logic [4:0]  r_rows, w_rows_nxt;
  logic [4:0]  r_row, w_row_nxt;
  logic [8:0]  r_yr, w_yr_nxt;
  logic [15:0] r_sptr, w_sptr_nxt;
  logic [15:0] r_spr, w_spr_nxt;
  logic        r_fb, w_fb_nxt;
  logic [1:0]  r_k, w_k_nxt;
  logic [15:0] r_rowbase, w_rowbase_nxt;
  logic [15:0] r_caddr, w_caddr_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;

  logic        w_yr_over;
  logic [8:0]  w_yr_eff;
  logic [2:0]  w_kmax;
  logic [2:0]  w_kc;
  logic [5:0]  w_col_raw;
  logic [5:0]  w_col;
  logic        w_col_ok;
  logic [15:0] w_col_addr;
  logic [23:0] w_shift;
  logic [7:0]  w_pix;

  assign ready          = r_ready;
  assign collision      = r_collision;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_addr       = r_mem_addr;
  assign mem_write_byte = r_mem_wbyte;

  // Screen row for the current sprite row, wrapped back onto the screen if needed
  always_comb begin
    w_yr_over = (32'(r_yr) >= SCREEN_H);
    w_yr_eff  = w_yr_over ? (r_yr - 9'(SCREEN_H)) : r_yr;
  end

  // Column dispatch: k=0 after the sprite fetch, k+1 after each store
  always_comb begin
    w_kmax    = 3'(r_wide) + 3'(r_x0[2:0] != 3'd0);
    w_kc      = (r_state == S_STORE) ? (3'(r_k) + 3'd1) : 3'd0;
    w_col_raw = 6'(r_x0[7:3]) + 6'(w_kc);
    w_col     = w_col_raw;
    w_col_ok  = (w_kc <= w_kmax);
    if (32'(w_col_raw) >= ROW_BYTES) begin
      if (r_wrap) w_col = w_col_raw - 6'(ROW_BYTES);
      else        w_col_ok = 1'b0;
    end
    w_col_addr = r_rowbase + 16'(w_col);
  end

  // Sprite row shifted to the pixel offset; one byte slice per touched column
  always_comb begin
    w_shift = {r_spr, 8'h00} >> r_x0[2:0];
    case (r_k)
      2'd0:    w_pix = w_shift[23:16];
      2'd1:    w_pix = w_shift[15:8];
      default: w_pix = w_shift[7:0];
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_collision_nxt = r_collision;
    w_mem_read_nxt  = 1'b0;
    w_mem_write_nxt = 1'b0;
    w_mem_addr_nxt  = 16'h0000;
    w_mem_wbyte_nxt = 8'h00;
    w_wide_nxt      = r_wide;
    w_wrap_nxt      = r_wrap;
    w_x0_nxt        = r_x0;
    w_rows_nxt      = r_rows;
    w_row_nxt       = r_row;
    w_yr_nxt        = r_yr;
    w_sptr_nxt      = r_sptr;
    w_spr_nxt       = r_spr;
    w_fb_nxt        = r_fb;
    w_k_nxt         = r_k;
    w_rowbase_nxt   = r_rowbase;
    w_caddr_nxt     = r_caddr;
    w_cnt_nxt       = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (clear) begin
          w_state_nxt     = S_CLEAR;
          w_collision_nxt = 1'b0;
          w_mem_write_nxt = 1'b1;
          w_mem_addr_nxt  = 16'(SCREEN_START);
          w_cnt_nxt       = 16'd1;
        end else if (draw) begin
          w_state_nxt     = S_NEXT_ROW;
          w_collision_nxt = 1'b0;
          w_wide_nxt      = wide;
          w_wrap_nxt      = wrap;
          w_sptr_nxt      = addr;
          w_x0_nxt        = 8'(32'(x) % SCREEN_W);
          w_yr_nxt        = 9'(32'(y) % SCREEN_H);
          w_rows_nxt      = (wide && lines == 4'd0) ? 5'd16 : 5'(lines);
          w_row_nxt       = 5'd0;
        end
      end
      S_NEXT_ROW: begin
        if (r_row == r_rows || (w_yr_over && !r_wrap)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_yr_nxt       = w_yr_eff;
          w_rowbase_nxt  = 16'(SCREEN_START) + 16'(32'(w_yr_eff) * ROW_BYTES);
          w_mem_read_nxt = 1'b1;
          w_mem_addr_nxt = r_sptr;
          w_sptr_nxt     = r_sptr + 16'd1;
          w_fb_nxt       = 1'b0;
          w_state_nxt    = S_FETCH;
        end
      end
      S_FETCH: begin
        // Strobe cycle waits; read data is valid the cycle after
        if (!r_mem_read) begin
          if (!r_fb) w_spr_nxt = {mem_read_byte, 8'h00};
          else       w_spr_nxt = {r_spr[15:8], mem_read_byte};
          if (r_wide && !r_fb) begin
            w_mem_read_nxt = 1'b1;
            w_mem_addr_nxt = r_sptr;
            w_sptr_nxt     = r_sptr + 16'd1;
            w_fb_nxt       = 1'b1;
          end else begin
            // First column is x0/8, always on screen
            w_k_nxt        = 2'd0;
            w_caddr_nxt    = w_col_addr;
            w_mem_read_nxt = 1'b1;
            w_mem_addr_nxt = w_col_addr;
            w_state_nxt    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (!r_mem_read) begin
          w_collision_nxt = r_collision | (|(mem_read_byte & w_pix));
          w_mem_write_nxt = 1'b1;
          w_mem_addr_nxt  = r_caddr;
          w_mem_wbyte_nxt = mem_read_byte ^ w_pix;
          w_state_nxt     = S_STORE;
        end
      end
      S_STORE: begin
        if (w_col_ok) begin
          w_k_nxt        = 2'(w_kc);
          w_caddr_nxt    = w_col_addr;
          w_mem_read_nxt = 1'b1;
          w_mem_addr_nxt = w_col_addr;
          w_state_nxt    = S_LOAD;
        end else begin
          w_row_nxt   = r_row + 5'd1;
          w_yr_nxt    = r_yr + 9'd1;
          w_state_nxt = S_NEXT_ROW;
        end
      end
      S_CLEAR: begin
        if (32'(r_cnt) < SCREEN_BYTES) begin
          w_mem_write_nxt = 1'b1;
          w_mem_addr_nxt  = 16'(SCREEN_START) + r_cnt;
          w_cnt_nxt       = r_cnt + 16'd1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_ready_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_collision <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wbyte <= 8'h00;
      r_wide      <= 1'b0;
      r_wrap      <= 1'b0;
      r_x0        <= 8'h00;
      r_rows      <= 5'd0;
      r_row       <= 5'd0;
      r_yr        <= 9'd0;
      r_sptr      <= 16'h0000;
      r_spr       <= 16'h0000;
      r_fb        <= 1'b0;
      r_k         <= 2'd0;
      r_rowbase   <= 16'h0000;
      r_caddr     <= 16'h0000;
      r_cnt       <= 16'h0000;
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= w_ready_nxt;
      r_collision <= w_collision_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wbyte <= w_mem_wbyte_nxt;
      r_wide      <= w_wide_nxt;
      r_wrap      <= w_wrap_nxt;
      r_x0        <= w_x0_nxt;
      r_rows      <= w_rows_nxt;
      r_row       <= w_row_nxt;
      r_yr        <= w_yr_nxt;
      r_sptr      <= w_sptr_nxt;
      r_spr       <= w_spr_nxt;
      r_fb        <= w_fb_nxt;
      r_k         <= w_k_nxt;
      r_rowbase   <= w_rowbase_nxt;
      r_caddr     <= w_caddr_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

endmodule

// File: doc/gpu_blit.md
Name: gpu_blit

Overview:
- Parametrised CHIP-8/SCHIP sprite blitter. XORs a sprite from main memory into a 1-bpp framebuffer held in the same memory and reports pixel collisions.
- Adds the following:
  - configurable screen size
  - 16x16 wide sprites (SCHIP)
  - per-draw wrap/clip mode
  - clear-screen command
  - skipping of the unneeded right-hand byte when x is byte-aligned
- Sits between the CPU's draw/clear instructions and the shared single-port memory arbiter.

Parameters:
- SCREEN_W, 64, screen width in pixels; multiple of 8, at most 256.
- SCREEN_H, 32, screen height in pixels; at most 256.
- SCREEN_START, 'h100, byte address of pixel (0,0); row-major, SCREEN_W/8 bytes per row, MSB = leftmost pixel.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- draw  in  1  start a draw; sampled only when ready=1.
- clear  in  1  start a screen clear; sampled only when ready=1; has priority over draw.
- wide  in  1  1 = 16-pixel-wide sprite, 2 bytes per row, big-endian (left byte first).
- wrap  in  1  1 = pixels past the right or bottom edge wrap; 0 = they are clipped.
- addr  in  16  sprite start address.
- lines  in  4  row count; 0 means 16 rows when wide=1, no-op when wide=0.
- x  in  8  X coordinate.
- y  in  8  Y coordinate.
- ready  out  1  high iff in IDLE.
- collision  out  1  1 if any set sprite pixel hit a set screen pixel during the last draw.
- mem_read  out  1  read strobe, one cycle wide.
- mem_write  out  1  write strobe, one cycle wide.
- mem_addr  out  16  memory address.
- mem_write_byte  out  8  write data.
- mem_read_byte  in  8  read data, valid the cycle after mem_read is high.

Behaviour:
- Reset (synchronous, active-high, also mid-operation):
  - state goes to IDLE; ready=1; collision=0.
  - mem_read, mem_write, mem_addr and mem_write_byte all go to 0.
  - Memory already written by an aborted operation stays as written.
- Strobe timing:
  - mem_read/mem_write are registered and high for exactly one cycle per access.
  - Never both high in the same cycle.
  - mem_addr/mem_write_byte are 0 whenever no strobe is high.
  - After a read strobe, the block samples mem_read_byte in the following cycle before issuing the next access.
- Command capture (IDLE, ready=1, same cycle):
  - clear=1: capture the clear command.
  - else draw=1: capture all inputs and set collision to 0.
  - Inputs are ignored while ready=0.
- Start coordinates always wrap: x0 = x mod SCREEN_W, y0 = y mod SCREEN_H. Applies in both wrap modes.
- Row count:
  - R = lines, or 16 if wide=1 and lines=0.
  - R=0: return to IDLE the next cycle, with no memory access and collision=0.
- Per row r = 0..R-1:
  - Screen row: yr = y0+r.
    - If yr >= SCREEN_H: wrap=1 uses yr-SCREEN_H; wrap=0 ends the draw (remaining rows skipped).
  - Sprite fetch: read B sprite bytes (B = 2 if wide, else 1) at addr + r*B onward.
    - Form the 24-bit shifted row as {sprite bits, zeros} >> (x0 mod 8).
  - Screen bytes touched: columns c = x0/8 + k, k = 0..B.
    - The k=B column is skipped when x0 mod 8 = 0.
    - If c >= SCREEN_W/8: wrap=1 uses c - SCREEN_W/8; wrap=0 skips the column (no read, no write).
  - For each touched column:
    - Read the screen byte S at SCREEN_START + yr*(SCREEN_W/8) + c.
    - collision |= |(S & P), where P is the matching slice of the shifted row.
    - Write S ^ P to the same address.
    - Every touched byte is written, even when P=0.
- States:
  - IDLE → FETCH (B reads) → for each column: LOAD (read) → STORE (write) → NEXT_ROW.
  - NEXT_ROW → FETCH while rows remain and the row is not clipped; else → IDLE.
  - CLEAR: handled separately, see below.
- Clear:
  - Writes 0 to SCREEN_W*SCREEN_H/8 consecutive bytes from SCREEN_START, in ascending address order, one write every cycle.
  - collision := 0.
  - Then → IDLE.
- Arithmetic: address arithmetic is 16-bit, modulo 2^16; row offsets use full-width multiply by SCREEN_W/8.

Test Plan:
- Narrow draw, SCREEN 64x32, x=0, y=0, lines=5, sprite "0" (F0 90 90 90 F0) on a zeroed screen → bytes 0x100,0x108,...,0x120 = F0,90,90,90,F0; byte 0x101 etc. not written; collision=0. Repeat the same draw → those bytes = 00; collision=1.
- x=60, y=0, sprite FF, wrap=1 → 0x107=0F, 0x100=F0, collision=0. Same stimulus with wrap=0 → 0x107=0F, 0x100 untouched (no write to it).
- y=30, lines=4, sprite FF at x=8, wrap=1 → rows 30,31,0,1 at byte 1 = FF. With wrap=0 → only rows 30,31 written; ready returns after 2 rows.
- SCREEN_W=128, SCREEN_H=64, wide=1, lines=0, x=3, y=0, all sprite bytes FF → each of rows 0..15 has bytes 0,1,2 = 1F,FF,E0. Pre-set bit 7 of byte 0 row 5 → that bit remains set and collision=0. Pre-set bit 0 of byte 0 row 5 instead → collision=1.
- clear on 128x64 → 1024 consecutive single-cycle writes of 00 from 0x100 to 0x4FF; ready=1 after the last write; collision=0.
- Priority and robustness:
  - draw=1 and clear=1 together → clear executes.
  - x=200, y=40 on 64x32 → drawn at (8,8).
  - reset asserted mid-draw → next cycle ready=1, all strobes 0, collision=0.
  - draw pulsed while busy → ignored.
